// File: rtl/lpf_tdm_sched_if.sv
// lpf_tdm_sched_if: control and data bundle for the time-multiplexed lowpass
// sequencer.
//   en          tick enable (master -> slave)
//   clear       synchronous clear of filter state (master -> slave)
//   in_bus      NCH packed 8-bit two's-complement samples (master -> slave)
//   out_bus     NCH packed 12-bit filter outputs (slave -> master)
//   frame_valid one-cycle pulse when a frame is complete (slave -> master)
//   busy        frame being sequenced (slave -> master)
//   cur_ch      channel updated this cycle (slave -> master)
//   overrun     sticky tick-while-busy flag (slave -> master)
interface lpf_tdm_sched_if #(
  parameter int NCH = 4,
  parameter int CW  = 3
);
  logic              en;
  logic              clear;
  logic [8*NCH-1:0]  in_bus;
  logic [12*NCH-1:0] out_bus;
  logic              frame_valid;
  logic              busy;
  logic [CW-1:0]     cur_ch;
  logic              overrun;

  modport master (
    output en, clear, in_bus,
    input  out_bus, frame_valid, busy, cur_ch, overrun
  );

  modport slave (
    input  en, clear, in_bus,
    output out_bus, frame_valid, busy, cur_ch, overrun
  );
endinterface

// File: rtl/lpf_tdm_sched.sv
// lpf_tdm_sched: sample-rate scheduler and round-robin sequencer for the
// abs_theta lowpass recurrence
//   y <= sx12(x) + sx12(x_prev) + y - (y >>> 3)   (mod 2^12)
// One shared update per clock walks channels 0..NCH-1 after every sample tick.
// Ports:
//   clk  system clock, rising edge
//   rst  asynchronous active-high reset
//   bus  lpf_tdm_sched_if.slave (en, clear, in_bus -> out_bus, frame_valid,
//        busy, cur_ch, overrun)
module lpf_tdm_sched #(
  parameter int NCH     = 4,
  parameter int CLK_DIV = 1250,
  parameter int CW      = 3
) (
  input  logic            clk,
  input  logic            rst,
  lpf_tdm_sched_if.slave  bus
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLK_DIV - 1);
  localparam logic [CW-1:0]    LAST_CH  = CW'(NCH - 1);

  if ((1 << CW) < NCH) begin : g_cw_check
    $error("lpf_tdm_sched: CW too narrow for NCH");
  end

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CW-1:0]     cur_ch_q, cur_ch_d;
  logic              frame_valid_q, frame_valid_d;
  logic              busy_q, busy_d;
  logic              overrun_q, overrun_d;
  logic [7:0]        snap_q [NCH];
  logic [7:0]        snap_d [NCH];
  logic [7:0]        xd_q   [NCH];
  logic [7:0]        xd_d   [NCH];
  logic [11:0]       y_q    [NCH];
  logic [11:0]       y_d    [NCH];

  logic              tick;
  logic [7:0]        sel_snap;
  logic [7:0]        sel_xd;
  logic [11:0]       sel_y;
  logic [11:0]       y_upd;

  assign tick = bus.en && (cnt_q == CNT_MAX);

  // Shared datapath: select the active channel's operands and form the update.
  always_comb begin
    sel_snap = '0;
    sel_xd   = '0;
    sel_y    = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      if (cur_ch_q == CW'(k)) begin
        sel_snap = snap_q[k];
        sel_xd   = xd_q[k];
        sel_y    = y_q[k];
      end
    end
    y_upd = {{4{sel_snap[7]}}, sel_snap}
          + {{4{sel_xd[7]}}, sel_xd}
          + sel_y
          - {{3{sel_y[11]}}, sel_y[11:3]};
  end

  always_comb begin
    state_d       = state_q;
    cur_ch_d      = cur_ch_q;
    busy_d        = busy_q;
    overrun_d     = overrun_q;
    frame_valid_d = 1'b0;
    snap_d        = snap_q;
    xd_d          = xd_q;
    y_d           = y_q;
    cnt_d         = (!bus.en || tick) ? '0 : cnt_q + 1'b1;

    if (bus.clear) begin
      cnt_d     = '0;
      state_d   = IDLE;
      cur_ch_d  = '0;
      busy_d    = 1'b0;
      overrun_d = 1'b0;
      for (int unsigned k = 0; k < NCH; k++) begin
        snap_d[k] = '0;
        xd_d[k]   = '0;
        y_d[k]    = '0;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          if (tick) begin
            for (int unsigned k = 0; k < NCH; k++) begin
              snap_d[k] = bus.in_bus[8*k +: 8];
            end
            state_d  = RUN;
            cur_ch_d = '0;
            busy_d   = 1'b1;
          end
        end
        RUN: begin
          // A tick mid-frame is dropped; the frame keeps its original snapshot.
          if (tick) begin
            overrun_d = 1'b1;
          end
          for (int unsigned k = 0; k < NCH; k++) begin
            if (cur_ch_q == CW'(k)) begin
              y_d[k]  = y_upd;
              xd_d[k] = snap_q[k];
            end
          end
          if (cur_ch_q == LAST_CH) begin
            state_d       = IDLE;
            cur_ch_d      = '0;
            busy_d        = 1'b0;
            frame_valid_d = 1'b1;
          end else begin
            cur_ch_d = cur_ch_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      cur_ch_q      <= '0;
      busy_q        <= 1'b0;
      overrun_q     <= 1'b0;
      frame_valid_q <= 1'b0;
      snap_q        <= '{default: '0};
      xd_q          <= '{default: '0};
      y_q           <= '{default: '0};
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      cur_ch_q      <= cur_ch_d;
      busy_q        <= busy_d;
      overrun_q     <= overrun_d;
      frame_valid_q <= frame_valid_d;
      snap_q        <= snap_d;
      xd_q          <= xd_d;
      y_q           <= y_d;
    end
  end

  // out_bus slice k is the registered filter state of channel k.
  always_comb begin
    bus.out_bus = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      bus.out_bus[12*k +: 12] = y_q[k];
    end
  end

  assign bus.frame_valid = frame_valid_q;
  assign bus.busy        = busy_q;
  assign bus.cur_ch      = cur_ch_q;
  assign bus.overrun     = overrun_q;

endmodule

// File: tb/tb_lpf_tdm_sched.sv
module tb_lpf_tdm_sched;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  lpf_tdm_sched_if #(.NCH(2), .CW(1)) ifa ();
  lpf_tdm_sched_if #(.NCH(4), .CW(2)) ifb ();

  lpf_tdm_sched #(.NCH(2), .CLK_DIV(8), .CW(1)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  lpf_tdm_sched #(.NCH(4), .CLK_DIV(4), .CW(2)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  int n_total = 0;
  int n_pass  = 0;

  logic [23:0] qa [$];
  logic [47:0] qb [$];

  logic [11:0] ya0, ya1;
  logic [7:0]  xda0, xda1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Reference recurrence in signed integer arithmetic, wrapped to 12 bits.
  function automatic logic [11:0] lpf(input logic [11:0] y, input logic [7:0] x,
                                      input logic [7:0] xd);
    int ys, r;
    ys = int'($signed(y));
    r  = ys + int'($signed(x)) + int'($signed(xd)) - (ys >>> 3);
    return r[11:0];
  endfunction

  task automatic model_reset_a();
    ya0 = '0; ya1 = '0; xda0 = '0; xda1 = '0;
  endtask

  task automatic model_frames_a(input logic [7:0] x0, input logic [7:0] x1, input int n);
    for (int i = 0; i < n; i++) begin
      ya0 = lpf(ya0, x0, xda0); xda0 = x0;
      ya1 = lpf(ya1, x1, xda1); xda1 = x1;
      qa.push_back({ya1, ya0});
    end
  endtask

  task automatic wait_empty_a(input string name);
    int n = 0;
    while (qa.size() != 0 && n < 3000) begin @(negedge clk); n++; end
    check(name, 64'(qa.size()), 0);
  endtask

  task automatic wait_empty_b(input string name);
    int n = 0;
    while (qb.size() != 0 && n < 200) begin @(negedge clk); n++; end
    check(name, 64'(qb.size()), 0);
  endtask

  // Scoreboard monitors: every frame_valid pops one expected out_bus image.
  always @(negedge clk) begin
    if (ifa.frame_valid) begin
      if (qa.size() == 0) check("a_unexpected_frame_valid", 64'(ifa.frame_valid), 0);
      else check("a_frame_out", 64'(ifa.out_bus), 64'(qa.pop_front()));
    end
    if (ifb.frame_valid) begin
      if (qb.size() == 0) check("b_unexpected_frame_valid", 64'(ifb.frame_valid), 0);
      else check("b_frame_out", 64'(ifb.out_bus), 64'(qb.pop_front()));
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int nfv;
    int per;

    ifa.en = 1'b0; ifa.clear = 1'b0; ifa.in_bus = '0;
    ifb.en = 1'b0; ifb.clear = 1'b0; ifb.in_bus = '0;
    model_reset_a();

    // Reset state
    #1 rst = 1'b1;
    @(negedge clk);
    check("reset_a", {ifa.out_bus, ifa.frame_valid, ifa.busy, ifa.cur_ch, ifa.overrun}, 0);
    check("reset_b", {ifb.out_bus, ifb.frame_valid, ifb.busy, ifb.cur_ch, ifb.overrun}, 0);
    rst = 1'b0;

    // Async reset in the middle of a frame (ch0 already holds 16)
    ifa.in_bus = {8'h00, 8'h10};
    ifa.en = 1'b1;
    n = 0;
    while (!(ifa.busy && ifa.cur_ch == 1'b1) && n < 40) begin @(negedge clk); n++; end
    check("a_mid_frame_before_rst", {ifa.out_bus, ifa.busy}, {24'h000010, 1'b1});
    #2 rst = 1'b1;
    #1 check("async_rst_a", {ifa.out_bus, ifa.frame_valid, ifa.busy, ifa.cur_ch, ifa.overrun}, 0);
    @(negedge clk);
    rst = 1'b0;
    ifa.en = 1'b0;
    nfv = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ifa.frame_valid) nfv++;
    end
    check("idle_no_frame_valid", 64'(nfv), 0);
    check("idle_out_zero", 64'(ifa.out_bus), 0);

    // Positive step on ch0 plus frame timing
    model_reset_a();
    ifa.in_bus = {8'h00, 8'h10};
    qa.push_back({12'd0, 12'd16});
    qa.push_back({12'd0, 12'd46});
    qa.push_back({12'd0, 12'd73});
    ya0 = 12'd73; xda0 = 8'h10;
    model_frames_a(8'h10, 8'h00, 57);
    ifa.en = 1'b1;
    n = 0;
    while (!ifa.busy && n < 40) begin @(negedge clk); n++; end
    check("t0_busy_cur_ch", {ifa.busy, ifa.cur_ch, ifa.out_bus}, {1'b1, 1'b0, 24'h0});
    @(negedge clk);
    check("t1_ch0_updated", {ifa.busy, ifa.cur_ch, ifa.frame_valid, ifa.out_bus},
          {1'b1, 1'b1, 1'b0, 24'h000010});
    @(negedge clk);
    check("t2_frame_valid", {ifa.busy, ifa.cur_ch, ifa.frame_valid}, {1'b0, 1'b0, 1'b1});
    @(negedge clk);
    check("t3_frame_valid_width", 64'(ifa.frame_valid), 0);
    per = 1;
    while (per < 40) begin
      @(negedge clk); per++;
      if (ifa.frame_valid) break;
    end
    check("frame_period", 64'(per), 8);
    wait_empty_a("a_pos_step_drain");
    ifa.en = 1'b0;
    check("pos_settle_ch0", 64'(ifa.out_bus[11:0]), 12'h100);
    check("pos_ch1_zero", 64'(ifa.out_bus[23:12]), 0);

    // Negative step on ch1 from cleared state
    @(negedge clk); ifa.clear = 1'b1;
    @(negedge clk); ifa.clear = 1'b0;
    check("clear_out_zero", 64'(ifa.out_bus), 0);
    model_reset_a();
    ifa.in_bus = {8'hF0, 8'h00};
    qa.push_back({12'hFF0, 12'd0});
    qa.push_back({12'hFD2, 12'd0});
    ya1 = 12'hFD2; xda1 = 8'hF0;
    model_frames_a(8'h00, 8'hF0, 58);
    ifa.en = 1'b1;
    wait_empty_a("a_neg_step_drain");
    ifa.en = 1'b0;
    check("neg_settle_range",
          64'(ifa.out_bus[23:12] >= 12'hF00 && ifa.out_bus[23:12] <= 12'hF07), 1);
    check("neg_ch0_zero", 64'(ifa.out_bus[11:0]), 0);

    // Clear while ch1 is the active channel
    ifa.in_bus = {8'h00, 8'h10};
    ifa.en = 1'b1;
    n = 0;
    while (!(ifa.busy && ifa.cur_ch == 1'b1) && n < 40) begin @(negedge clk); n++; end
    check("clear_wait_cur_ch1", {ifa.busy, ifa.cur_ch}, {1'b1, 1'b1});
    ifa.clear = 1'b1;
    @(negedge clk);
    check("clear_mid_frame", {ifa.out_bus, ifa.frame_valid, ifa.busy, ifa.cur_ch}, 0);
    ifa.clear = 1'b0;
    model_reset_a();
    model_frames_a(8'h10, 8'h00, 1);
    wait_empty_a("a_after_clear_drain");
    ifa.en = 1'b0;
    check("after_clear_ch0", 64'(ifa.out_bus[11:0]), 12'd16);

    // Overrun on the 4-channel instance; snapshot must survive in_bus changes
    ifb.in_bus = {8'h80, 8'h7F, 8'hF0, 8'h10};
    qb.push_back({12'hF80, 12'h07F, 12'hFF0, 12'h010});
    ifb.en = 1'b1;
    n = 0;
    while (!ifb.busy && n < 40) begin @(negedge clk); n++; end
    check("b_busy", 64'(ifb.busy), 1);
    ifb.in_bus = {4{8'h55}};
    wait_empty_b("b_frame_drain");
    ifb.en = 1'b0;
    check("b_overrun_set", 64'(ifb.overrun), 1);
    repeat (6) @(negedge clk);
    check("b_overrun_sticky", {ifb.overrun, ifb.busy, ifb.out_bus},
          {1'b1, 1'b0, 12'hF80, 12'h07F, 12'hFF0, 12'h010});
    ifb.clear = 1'b1;
    @(negedge clk);
    ifb.clear = 1'b0;
    check("b_clear_overrun", {ifb.overrun, ifb.out_bus}, 0);

    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
